dmg_clk_gen: RTL and testbench
==============================

Name: dmg_clk_gen

Overview:
- DMG SoC clock generator between the oscillator pad and the CPU core / peripherals.
- Derives the 4-phase T-state sequence, a machine-cycle clock, CPU clock enable, memory write/read strobes, a stretched system reset and a free-running divider.
- Single clock domain: the pad oscillator, delivered inverted.

Parameters:
- RESET_HOLD, 16: oscillator cycles sys_reset stays high after reset release with osc_stable=1.
- DIV_WIDTH, 16: width of the free-running divider.

Ports:
- n_clk_in  in  1  inverted oscillator; all state updates on rising edge of n_clk_in
- reset  in  1  synchronous, active-high
- osc_ena  in  1  1=oscillator running; 0=freeze all state (STOP)
- clk_ena  in  1  1=CPU clocks run; 0=CPU phases park at T0 (HALT)
- osc_stable  in  1  oscillator settled; gates reset release
- test_1  in  1  test mode enable
- n_test_reset  in  1  active-low test reset; honoured only when test_1=1
- cpu_mreq  in  1  CPU memory request for current M-cycle
- cpu_wr  in  1  1=write, 0=read (valid with cpu_mreq)
- t_phase  out  4  one-hot T-state, bit0=T0 .. bit3=T3
- phase  out  2  binary T-state
- m_clk  out  1  machine clock: 1 in T0,T1; 0 in T2,T3
- cpu_clk_ena  out  1  1 when the CPU may advance this cycle
- n_wr  out  1  active-low write strobe
- n_rd  out  1  active-low read strobe
- sys_reset  out  1  stretched system reset
- div  out  DIV_WIDTH  free-running divider

Behaviour:
- All outputs registered; no combinational input-to-output paths.
- Reset (reset=1, sampled on clock edge), regardless of osc_ena:
  - phase=0, t_phase=4'b0001, m_clk=1, cpu_clk_ena=0, n_wr=1, n_rd=1, sys_reset=1, div=0, hold counter=0.
- Reset stretcher:
  - After reset=0, hold counter increments each cycle only while osc_stable=1 and osc_ena=1; osc_stable=0 clears it.
  - sys_reset falls on the edge where the counter reaches RESET_HOLD, then stays 0 until the next reset.
- Phase sequencer (runs only when sys_reset=0 and osc_ena=1):
  - phase steps 0->1->2->3->0 each cycle; t_phase and m_clk decode it, so one M-cycle is 4 clocks.
  - If clk_ena=0 when phase=3 (or while phase=0), phase goes/stays 0; an M-cycle in progress always completes.
  - Resumes from T0 on the cycle after clk_ena returns to 1.
- cpu_clk_ena: 1 when sys_reset=0, osc_ena=1, clk_ena=1; else 0.
- Strobes:
  - cpu_mreq/cpu_wr are sampled at the end of T1.
  - If cpu_mreq=1: n_wr (cpu_wr=1) or n_rd (cpu_wr=0) is 0 during T2 and T3, returning to 1 at T0.
  - Never both low. Forced to 1 while sys_reset=1 or when parked.
- Divider:
  - div increments by 1 every cycle when osc_ena=1 and sys_reset=0; wraps all-ones -> 0.
  - Unaffected by clk_ena.
- osc_ena=0:
  - All registers hold, except cpu_clk_ena, which drops to 0 immediately on the next edge.
  - Resuming continues from the held state.
- Test mode: test_1=1 and n_test_reset=0 behaves as reset=1 for phase, div and strobes only; sys_reset is unaffected. test_1=0 ignores n_test_reset.
- Priority: reset > test reset > osc_ena=0 > clk_ena park > normal stepping.
- Reset asserted mid-M-cycle aborts it: strobes go high and phase=0 on that edge.

Test Plan:
- reset=1 for 8 cycles, then 0, osc_stable=1, clk_ena=1 -> sys_reset=0 exactly 16 cycles after release; phase then cycles 0,1,2,3 (t_phase 1,2,4,8), m_clk 1,1,0,0.
- osc_stable=0 for 5 cycles after reset release, then 1 -> sys_reset falls 16 cycles after osc_stable rises.
- cpu_mreq=1, cpu_wr=1 during T1 -> n_wr=0 in T2,T3 and n_rd=1; with cpu_wr=0 -> n_rd=0 in T2,T3 and n_wr=1.
- clk_ena=0 asserted at T1 -> phase runs to 3, then holds 0 with cpu_clk_ena=0; div keeps incrementing; clk_ena=1 -> phase=1 next cycle.
- osc_ena=0 for 10 cycles at div=0x0042 -> div, phase frozen, cpu_clk_ena=0; on resume div continues from 0x0043.
- test_1=1, n_test_reset=0 for 1 cycle at div=0x1234 -> div=0, phase=0, sys_reset stays 0; same with test_1=0 -> no effect.

Source files
------------

// File: rtl/dmg_clk_gen_if.sv
// Control inputs and registered clock/strobe outputs of the DMG clock generator.
// master drives the oscillator/CPU controls, slave is the generator itself.
interface dmg_clk_gen_if #(
  parameter int DIV_WIDTH = 16
);
  logic                 osc_ena;
  logic                 clk_ena;
  logic                 osc_stable;
  logic                 test_1;
  logic                 n_test_reset;
  logic                 cpu_mreq;
  logic                 cpu_wr;
  logic [3:0]           t_phase;
  logic [1:0]           phase;
  logic                 m_clk;
  logic                 cpu_clk_ena;
  logic                 n_wr;
  logic                 n_rd;
  logic                 sys_reset;
  logic [DIV_WIDTH-1:0] div;

  modport master (
    output osc_ena, clk_ena, osc_stable, test_1, n_test_reset, cpu_mreq, cpu_wr,
    input  t_phase, phase, m_clk, cpu_clk_ena, n_wr, n_rd, sys_reset, div
  );

  modport slave (
    input  osc_ena, clk_ena, osc_stable, test_1, n_test_reset, cpu_mreq, cpu_wr,
    output t_phase, phase, m_clk, cpu_clk_ena, n_wr, n_rd, sys_reset, div
  );
endinterface

// File: rtl/dmg_clk_gen.sv
// DMG clock generator: T-state sequencer, M-clock, CPU enable, memory strobes, reset stretcher, divider.
// Every output is a flop (1-cycle latency); no backpressure, CPU is throttled by clk_ena park and osc_ena freeze.
module dmg_clk_gen #(
  parameter int RESET_HOLD = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic          n_clk_in,
  input  logic          reset,
  dmg_clk_gen_if.slave  bus
);
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);

  logic [1:0]           phase_q, phase_d;
  logic [3:0]           t_phase_q, t_phase_d;
  logic                 m_clk_q, m_clk_d;
  logic                 cpu_clk_ena_q, cpu_clk_ena_d;
  logic                 n_wr_q, n_wr_d;
  logic                 n_rd_q, n_rd_d;
  logic                 sys_reset_q, sys_reset_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic                 test_rst;

  always_comb begin
    phase_d       = phase_q;
    n_wr_d        = n_wr_q;
    n_rd_d        = n_rd_q;
    div_d         = div_q;
    hold_cnt_d    = hold_cnt_q;
    sys_reset_d   = sys_reset_q;
    test_rst      = bus.test_1 & ~bus.n_test_reset;

    // Stretcher: counts settled oscillator cycles, restarts whenever the pad goes unstable.
    if (bus.osc_ena && sys_reset_q) begin
      if (!bus.osc_stable) begin
        hold_cnt_d = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (hold_cnt_d == HOLD_W'(RESET_HOLD)) begin
          sys_reset_d = 1'b0;
        end
      end
    end

    if (test_rst) begin
      phase_d = 2'd0;
      n_wr_d  = 1'b1;
      n_rd_d  = 1'b1;
      div_d   = '0;
    end else if (bus.osc_ena && !sys_reset_q) begin
      div_d = div_q + DIV_WIDTH'(1);
      // A started M-cycle always runs to T3; clk_ena only decides whether T0 is left.
      unique case (phase_q)
        2'd0: phase_d = bus.clk_ena ? 2'd1 : 2'd0;
        2'd1: begin
          phase_d = 2'd2;
          n_wr_d  = ~(bus.cpu_mreq & bus.cpu_wr);
          n_rd_d  = ~(bus.cpu_mreq & ~bus.cpu_wr);
        end
        2'd2: phase_d = 2'd3;
        default: begin
          phase_d = 2'd0;
          n_wr_d  = 1'b1;
          n_rd_d  = 1'b1;
        end
      endcase
    end

    t_phase_d     = 4'b0001 << phase_d;
    m_clk_d       = ~phase_d[1];
    cpu_clk_ena_d = bus.osc_ena & bus.clk_ena & ~sys_reset_d;
  end

  always_ff @(posedge n_clk_in) begin
    if (reset) begin
      phase_q       <= 2'd0;
      t_phase_q     <= 4'b0001;
      m_clk_q       <= 1'b1;
      cpu_clk_ena_q <= 1'b0;
      n_wr_q        <= 1'b1;
      n_rd_q        <= 1'b1;
      sys_reset_q   <= 1'b1;
      div_q         <= '0;
      hold_cnt_q    <= '0;
    end else begin
      phase_q       <= phase_d;
      t_phase_q     <= t_phase_d;
      m_clk_q       <= m_clk_d;
      cpu_clk_ena_q <= cpu_clk_ena_d;
      n_wr_q        <= n_wr_d;
      n_rd_q        <= n_rd_d;
      sys_reset_q   <= sys_reset_d;
      div_q         <= div_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.t_phase     = t_phase_q;
  assign bus.m_clk       = m_clk_q;
  assign bus.cpu_clk_ena = cpu_clk_ena_q;
  assign bus.n_wr        = n_wr_q;
  assign bus.n_rd        = n_rd_q;
  assign bus.sys_reset   = sys_reset_q;
  assign bus.div         = div_q;
endmodule

// File: tb/tb_dmg_clk_gen.sv
// Bench for dmg_clk_gen: directed per-cycle expectations queued by the stimulus, checked by a monitor after each edge.
module tb_dmg_clk_gen;
  logic n_clk_in = 1'b0;
  logic reset;

  dmg_clk_gen_if #(.DIV_WIDTH(16)) bus ();

  dmg_clk_gen #(.RESET_HOLD(16), .DIV_WIDTH(16)) dut (
    .n_clk_in (n_clk_in),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 n_clk_in = ~n_clk_in;

  // -1 in a field means that field is not checked for this cycle.
  typedef struct {
    string nm;
    int    ph;
    int    sr;
    int    dv;
    int    ce;
    int    wr;
    int    rd;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_ph   = 0;
  int   exp_div  = 0;

  task automatic chk(input string nm, input string fld, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, fld, act, act, req, req, $time);
    end
  endtask

  always @(posedge n_clk_in) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.ph >= 0) begin
        chk(e.nm, "phase",   int'(bus.phase),   e.ph);
        chk(e.nm, "t_phase", int'(bus.t_phase), 1 << e.ph);
        chk(e.nm, "m_clk",   int'(bus.m_clk),   (e.ph < 2) ? 1 : 0);
      end
      if (e.sr >= 0) chk(e.nm, "sys_reset",   int'(bus.sys_reset),   e.sr);
      if (e.dv >= 0) chk(e.nm, "div",         int'(bus.div),         e.dv);
      if (e.ce >= 0) chk(e.nm, "cpu_clk_ena", int'(bus.cpu_clk_ena), e.ce);
      if (e.wr >= 0) chk(e.nm, "n_wr",        int'(bus.n_wr),        e.wr);
      if (e.rd >= 0) chk(e.nm, "n_rd",        int'(bus.n_rd),        e.rd);
    end
  end

  // Queue what the outputs must be after the coming edge, then let that edge pass.
  task automatic tick(input string nm, input int ph, input int sr, input int dv,
                      input int ce, input int wr, input int rd);
    exp_t e;
    e.nm = nm; e.ph = ph; e.sr = sr; e.dv = dv; e.ce = ce; e.wr = wr; e.rd = rd;
    sb_q.push_back(e);
    @(posedge n_clk_in);
    @(negedge n_clk_in);
  endtask

  task automatic adv();
    exp_ph  = (exp_ph + 1) % 4;
    exp_div = (exp_div + 1) & 16'hFFFF;
  endtask

  task automatic run(input string nm);
    adv();
    tick(nm, exp_ph, 0, exp_div, 1, 1, 1);
  endtask

  initial begin
    reset            = 1'b1;
    bus.osc_ena      = 1'b1;
    bus.clk_ena      = 1'b1;
    bus.osc_stable   = 1'b1;
    bus.test_1       = 1'b0;
    bus.n_test_reset = 1'b1;
    bus.cpu_mreq     = 1'b0;
    bus.cpu_wr       = 1'b0;
    @(negedge n_clk_in);

    repeat (8) tick("reset", 0, 1, 0, 0, 1, 1);
    reset = 1'b0;
    repeat (15) tick("stretch", 0, 1, 0, 0, 1, 1);
    tick("release", 0, 0, 0, -1, 1, 1);
    exp_ph = 0; exp_div = 0;
    repeat (4) run("seq");

    // Write then read M-cycles, request presented only during T1.
    run("t1_wr");
    bus.cpu_mreq = 1'b1; bus.cpu_wr = 1'b1;
    adv(); tick("wr_t2", exp_ph, 0, exp_div, 1, 0, 1);
    bus.cpu_mreq = 1'b0;
    adv(); tick("wr_t3", exp_ph, 0, exp_div, 1, 0, 1);
    run("wr_t0");
    run("t1_rd");
    bus.cpu_mreq = 1'b1; bus.cpu_wr = 1'b0;
    adv(); tick("rd_t2", exp_ph, 0, exp_div, 1, 1, 0);
    bus.cpu_mreq = 1'b0;
    adv(); tick("rd_t3", exp_ph, 0, exp_div, 1, 1, 0);
    run("rd_t0");

    // HALT requested in T1: cycle completes, then parks at T0 while div keeps counting.
    run("pre_park");
    bus.clk_ena = 1'b0;
    adv(); tick("park_t2", exp_ph, 0, exp_div, 0, 1, 1);
    adv(); tick("park_t3", exp_ph, 0, exp_div, 0, 1, 1);
    adv(); tick("park_t0", exp_ph, 0, exp_div, 0, 1, 1);
    repeat (2) begin
      exp_div++;
      tick("parked", 0, 0, exp_div, 0, 1, 1);
    end
    bus.clk_ena = 1'b1;
    run("unpark");

    while (exp_div != 16'h0042) run("to_42");
    bus.osc_ena = 1'b0;
    repeat (10) tick("osc_freeze", exp_ph, 0, exp_div, 0, 1, 1);
    bus.osc_ena = 1'b1;
    run("osc_resume");

    while (exp_div != 16'h1234) run("to_1234");
    bus.test_1 = 1'b1; bus.n_test_reset = 1'b0;
    exp_ph = 0; exp_div = 0;
    tick("test_rst", 0, 0, 0, 1, 1, 1);
    bus.test_1 = 1'b0; bus.n_test_reset = 1'b1;
    run("after_trst");
    bus.n_test_reset = 1'b0;
    run("trst_ignored");
    bus.n_test_reset = 1'b1;
    repeat (3) run("pre_abort");

    // Reset in the middle of a write cycle aborts it on that edge.
    bus.cpu_mreq = 1'b1; bus.cpu_wr = 1'b1;
    adv(); tick("abort_t2", exp_ph, 0, exp_div, 1, 0, 1);
    bus.cpu_mreq = 1'b0;
    reset = 1'b1; bus.osc_stable = 1'b0;
    tick("abort", 0, 1, 0, 0, 1, 1);
    reset = 1'b0; bus.osc_stable = 1'b1;
    repeat (3) tick("stable_a", 0, 1, 0, 0, 1, 1);
    bus.osc_stable = 1'b0;
    repeat (5) tick("unstable", 0, 1, 0, 0, 1, 1);
    bus.osc_stable = 1'b1;
    repeat (15) tick("restretch", 0, 1, 0, 0, 1, 1);
    tick("rerelease", 0, 0, 0, -1, 1, 1);
    exp_ph = 0; exp_div = 0;
    bus.osc_stable = 1'b0;
    run("stays_low");
    run("stays_low");

    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge n_clk_in);
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
